data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//   Responder end of the pipeline MEM-stage data-memory interface. Accepts byte/word
//   load/store requests from the MEM stage, models fixed wait states and returns
//   load data with a one-cycle ready pulse. Drives a stall back to the pipeline
//   while a request is outstanding. Byte-addressed, big-endian storage array.
// PARAMETERS
//   ADDR_W       8    byte-address width
//   DEPTH        256  storage size in bytes; power of 2, multiple of 4
//   WAIT_STATES  1    extra cycles between accept and access; 0..7
// PORTS
//   clk        in   1       clock, all state updates on posedge
//   reset      in   1       synchronous, active-high
//   enable     in   1       request valid from MEM stage
//   rw         in   1       1 = store, 0 = load
//   size       in   1       1 = word (32b), 0 = byte
//   address    in   ADDR_W  byte address
//   data_in    in   32      store data; byte store uses [7:0]
//   data_out   out  32      load data, registered, valid while ready=1
//   ready      out  1       one-cycle completion pulse
//   busy       out  1       state != IDLE
//   stall      out  1       enable & ~ready (combinational, to PC/IF-ID LE)
//   err        out  1       misalign flag (see CONFIGURATION); 0 when unused
// BEHAVIOUR
//   - Reset: state=IDLE, data_out=0, ready=0, err=0, wait counter=0. Storage array
//     (named Mem[0:DEPTH-1], 8b entries) is NOT cleared; the bench preloads it
//     hierarchically.
//   - FSM IDLE -> WAIT -> DONE -> IDLE.
//     IDLE: enable=1 at edge -> capture rw/size/address/data_in, cnt<=WAIT_STATES,
//           go WAIT. Otherwise stay.
//     WAIT: cnt!=0 -> cnt<=cnt-1. cnt==0 -> perform access at this edge, go DONE.
//     DONE: ready=1 for exactly one cycle; enable ignored; next edge -> IDLE.
//   - Latency: ready is high in the cycle after edge (accept + WAIT_STATES + 1).
//     WAIT_STATES=0: accept at E0, ready between E1 and E2.
//   - Throughput: one request per WAIT_STATES+3 cycles; enable held high re-issues
//     (new accept in IDLE after DONE). Initiator drops enable after ready.
//   - Captured fields are frozen; changes on inputs during WAIT/DONE ignored.
//   - Word access: effective addr a = {address[ADDR_W-1:2],2'b00}; load
//     data_out={Mem[a],Mem[a+1],Mem[a+2],Mem[a+3]} (Mem[a] = MSB); store writes same
//     order. Byte load: data_out={24'b0,Mem[address]}. Byte store: Mem[address]<=
//     data_in[7:0]. Store completion: data_out unchanged.
//   - Addresses index modulo DEPTH (upper bits above log2(DEPTH) ignored).
//   - Reset during WAIT: pending store dropped, Mem unchanged, no ready pulse.
//   - enable=0 in IDLE: nothing changes, stall=0.
// CONFIGURATION
//   DMEM_MISALIGN_TRAP_EN
//     defined: word access with address[1:0]!=0 is not performed (no Mem write,
//       data_out<=0), err=1 together with ready for the same single cycle.
//     undefined: address[1:0] silently forced to 00 as above; err tied 0.
// STRUCTURE
//   - Package dmem_pkg: state encoding (IDLE/WAIT/DONE), SIZE_BYTE=1'b0,
//     SIZE_WORD=1'b1, RW_LOAD=1'b0, RW_STORE=1'b1.
//   - One sub-module: dmem_byte_array (DEPTH x 8 storage, 4-lane big-endian
//     read/write port, byte-enable write); FSM and counter stay in top.
// TESTING
//   1 Reset: assert reset 2 cycles -> data_out=0, ready=0, busy=0, stall=0.
//   2 Word store then load, WAIT_STATES=1: store 0xDEADBEEF @0x10 -> ready 2 cycles
//     after accept; Mem[0x10..0x13]=DE,AD,BE,EF; load @0x10 -> data_out=0xDEADBEEF.
//   3 Byte ops: byte store 0x5A @0x13 then word load @0x10 -> 0xDEADBE5A; byte load
//     @0x11 -> 0x000000AD.
//   4 Stall/back-to-back: enable held high for 2 loads -> stall=1 except the ready
//     cycles; exactly 2 ready pulses, one per WAIT_STATES+3 cycles.
//   5 Reset mid-op: store 0x11223344 @0x20, reset in WAIT -> no ready, Mem[0x20..23]
//     keeps prior contents, state IDLE.
//   6 Misaligned word load @0x12: with DMEM_MISALIGN_TRAP_EN -> err=1, data_out=0;
//     without -> err=0, data_out = word @0x10.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data-memory responder.
//   dmem_state_e : responder FSM encoding (idle / wait-state countdown / completion)
//   SIZE_* / RW_*: request field encodings as seen on the size and rw inputs
package dmem_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StDone = 2'd2
    } dmem_state_e;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;
    localparam logic RW_LOAD   = 1'b0;
    localparam logic RW_STORE  = 1'b1;

endpackage

// File: rtl/dmem_byte_array.sv
// DEPTH x 8 byte storage exposing one word-wide, big-endian lane port.
//   clk     : write clock
//   we      : write strobe, qualified per lane by be
//   base    : word index (byte index without its two low bits)
//   be      : lane enables, be[3] = lane at base*4 (MSB), be[0] = base*4+3 (LSB)
//   wdata   : write data, [31:24] goes to the lowest byte address
//   rdata   : combinational read of the four bytes at base, lowest address in [31:24]
// Storage is intentionally never reset.
module dmem_byte_array #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned IdxW  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [IdxW-3:0] base,
    input  logic [3:0]      be,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata
);

    logic [7:0] Mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int l = 0; l < 4; l++) begin
                if (be[3-l]) begin
                    Mem[{base, 2'(l)}] <= wdata[31-8*l -: 8];
                end
            end
        end
    end

    assign rdata = {Mem[{base, 2'd0}], Mem[{base, 2'd1}], Mem[{base, 2'd2}], Mem[{base, 2'd3}]};

endmodule

// File: rtl/data_mem_responder.sv
// Responder side of the MEM-stage data-memory interface. Accepts one byte/word
// load/store, counts WAIT_STATES cycles, performs the access, then pulses ready.
//   clk, reset      : clock; synchronous active-high reset
//   enable, rw, size: request valid, 1=store/0=load, 1=word/0=byte
//   address, data_in: byte address, store data (byte store uses [7:0])
//   data_out        : registered load data, valid while ready=1
//   ready           : one-cycle completion pulse
//   busy            : FSM not idle
//   stall           : enable & ~ready, back to the pipeline
//   err             : misaligned word access flag
// Optional feature macro: DMEM_MISALIGN_TRAP_EN. When defined a misaligned word
// access is suppressed and flagged on err alongside ready; otherwise the low
// address bits are ignored for word accesses and err is tied low.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              rw,
    input  logic              size,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       data_in,
    output logic [31:0]       data_out,
    output logic              ready,
    output logic              busy,
    output logic              stall,
    output logic              err
);

    localparam int unsigned IdxW = $clog2(DEPTH);

    dmem_state_e       state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              rw_q, rw_d;
    logic              size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       data_out_q, data_out_d;

    logic [IdxW-1:0]   idx;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic [7:0]        byte_rd;
    logic              trap;

    // Index modulo DEPTH: upper address bits are dropped here.
    assign idx = IdxW'(addr_q);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign trap = (size_q == SIZE_WORD) && (idx[1:0] != 2'b00);
    assign err  = (state_q == StDone) && trap;
`else
    assign trap = 1'b0;
    assign err  = 1'b0;
`endif

    assign mem_be    = (size_q == SIZE_WORD) ? 4'hF : (4'b1000 >> idx[1:0]);
    assign mem_wdata = (size_q == SIZE_WORD) ? wdata_q : {4{wdata_q[7:0]}};

    always_comb begin
        byte_rd = mem_rdata[31:24];
        case (idx[1:0])
            2'd1:    byte_rd = mem_rdata[23:16];
            2'd2:    byte_rd = mem_rdata[15:8];
            2'd3:    byte_rd = mem_rdata[7:0];
            default: byte_rd = mem_rdata[31:24];
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rw_d       = rw_q;
        size_d     = size_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        data_out_d = data_out_q;
        mem_we     = 1'b0;
        case (state_q)
            StIdle: begin
                if (enable) begin
                    rw_d    = rw;
                    size_d  = size;
                    addr_d  = address;
                    wdata_d = data_in;
                    cnt_d   = 3'(WAIT_STATES);
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    state_d = StDone;
                    if (trap) begin
                        data_out_d = 32'h0;
                    end else if (rw_q == RW_LOAD) begin
                        data_out_d = (size_q == SIZE_WORD) ? mem_rdata : {24'h0, byte_rd};
                    end else begin
                        // Reset in the same cycle drops the pending store.
                        mem_we = ~reset;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= 3'd0;
            rw_q       <= RW_LOAD;
            size_q     <= SIZE_BYTE;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            data_out_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rw_q       <= rw_d;
            size_q     <= size_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            data_out_q <= data_out_d;
        end
    end

    dmem_byte_array #(
        .DEPTH (DEPTH),
        .IdxW  (IdxW)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .base  (idx[IdxW-1:2]),
        .be    (mem_be),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    assign data_out = data_out_q;
    assign ready    = (state_q == StDone);
    assign busy     = (state_q != StIdle);
    assign stall    = enable & ~ready;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        rw;
    logic        size;
    logic [7:0]  address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        ready;
    logic        busy;
    logic        stall;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    data_mem_responder #(
        .ADDR_W      (8),
        .DEPTH       (256),
        .WAIT_STATES (1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .rw       (rw),
        .size     (size),
        .address  (address),
        .data_in  (data_in),
        .data_out (data_out),
        .ready    (ready),
        .busy     (busy),
        .stall    (stall),
        .err      (err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One request; inputs are scrambled after accept to confirm capture is frozen.
    task automatic do_op(input logic rw_v, input logic size_v, input logic [7:0] addr_v,
                         input logic [31:0] din_v, output int lat,
                         output logic [31:0] dout, output logic errv);
        enable  = 1'b1;
        rw      = rw_v;
        size    = size_v;
        address = addr_v;
        data_in = din_v;
        step();
        enable  = 1'b0;
        rw      = ~rw_v;
        size    = ~size_v;
        address = ~addr_v;
        data_in = ~din_v;
        lat = 0;
        while (ready !== 1'b1 && lat < 10) begin
            step();
            lat++;
        end
        dout = data_out;
        errv = err;
        step();
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b0;
        step();
        step();
        n_checks++;
        if (data_out !== 32'h0) begin
            n_fail++; $display("FAIL reset_data_out: got %h expected %h", data_out, 32'h0);
        end
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 0", ready);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b expected 0", busy);
        end
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall: got %b expected 0", stall);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_word();
        int          lat;
        logic [31:0] d;
        logic        e;
        logic [31:0] mem_word;
        do_op(1'b1, 1'b1, 8'h10, 32'hDEADBEEF, lat, d, e);
        n_checks++;
        if (lat !== 2) begin
            n_fail++; $display("FAIL store_latency: got %0d expected 2", lat);
        end
        mem_word = {dut.u_array.Mem[8'h10], dut.u_array.Mem[8'h11],
                    dut.u_array.Mem[8'h12], dut.u_array.Mem[8'h13]};
        n_checks++;
        if (mem_word !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL store_mem_bytes: got %h expected DEADBEEF", mem_word);
        end
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL store_data_out_unchanged: got %h expected 0", d);
        end
        do_op(1'b0, 1'b1, 8'h10, 32'h0, lat, d, e);
        n_checks++;
        if (lat !== 2) begin
            n_fail++; $display("FAIL load_latency: got %0d expected 2", lat);
        end
        n_checks++;
        if (d !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL word_load: got %h expected DEADBEEF", d);
        end
        n_checks++;
        if (e !== 1'b0) begin
            n_fail++; $display("FAIL word_load_err: got %b expected 0", e);
        end
    endtask

    task automatic test_byte();
        int          lat;
        logic [31:0] d;
        logic        e;
        do_op(1'b1, 1'b0, 8'h13, 32'hFFFFFF5A, lat, d, e);
        do_op(1'b0, 1'b1, 8'h10, 32'h0, lat, d, e);
        n_checks++;
        if (d !== 32'hDEADBE5A) begin
            n_fail++; $display("FAIL byte_store_word_load: got %h expected DEADBE5A", d);
        end
        do_op(1'b0, 1'b0, 8'h11, 32'h0, lat, d, e);
        n_checks++;
        if (d !== 32'h000000AD) begin
            n_fail++; $display("FAIL byte_load: got %h expected 000000AD", d);
        end
    endtask

    task automatic test_back_to_back();
        int   pulses = 0;
        logic exp_rdy;
        enable  = 1'b1;
        rw      = 1'b0;
        size    = 1'b1;
        address = 8'h10;
        for (int i = 0; i < 8; i++) begin
            step();
            exp_rdy = (i == 2) || (i == 6);
            if (ready === 1'b1) pulses++;
            n_checks++;
            if (ready !== exp_rdy) begin
                n_fail++; $display("FAIL b2b_ready[%0d]: got %b expected %b", i, ready, exp_rdy);
            end
            n_checks++;
            if (stall !== ~exp_rdy) begin
                n_fail++; $display("FAIL b2b_stall[%0d]: got %b expected %b", i, stall, ~exp_rdy);
            end
            if (exp_rdy) begin
                n_checks++;
                if (data_out !== 32'hDEADBE5A) begin
                    n_fail++; $display("FAIL b2b_data[%0d]: got %h expected DEADBE5A", i, data_out);
                end
            end
        end
        enable = 1'b0;
        step();
        n_checks++;
        if (pulses !== 2) begin
            n_fail++; $display("FAIL b2b_pulse_count: got %0d expected 2", pulses);
        end
    endtask

    task automatic test_reset_mid();
        int          lat;
        int          pulses = 0;
        logic [31:0] d;
        logic        e;
        logic [31:0] mem_word;
        do_op(1'b1, 1'b1, 8'h20, 32'hCAFEF00D, lat, d, e);
        enable  = 1'b1;
        rw      = 1'b1;
        size    = 1'b1;
        address = 8'h20;
        data_in = 32'h11223344;
        step();
        enable = 1'b0;
        step();
        // Counter has reached zero; the next edge would perform the store.
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL midreset_busy: got %b expected 0", busy);
        end
        for (int i = 0; i < 4; i++) begin
            if (ready === 1'b1) pulses++;
            step();
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++; $display("FAIL midreset_ready_pulses: got %0d expected 0", pulses);
        end
        mem_word = {dut.u_array.Mem[8'h20], dut.u_array.Mem[8'h21],
                    dut.u_array.Mem[8'h22], dut.u_array.Mem[8'h23]};
        n_checks++;
        if (mem_word !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL midreset_mem: got %h expected CAFEF00D", mem_word);
        end
        do_op(1'b0, 1'b1, 8'h20, 32'h0, lat, d, e);
        n_checks++;
        if (d !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL midreset_load: got %h expected CAFEF00D", d);
        end
    endtask

    task automatic test_misalign();
        int          lat;
        logic [31:0] d;
        logic        e;
        logic [31:0] exp_d;
        logic        exp_e;
`ifdef DMEM_MISALIGN_TRAP_EN
        exp_d = 32'h0;
        exp_e = 1'b1;
`else
        exp_d = 32'hDEADBE5A;
        exp_e = 1'b0;
`endif
        do_op(1'b0, 1'b1, 8'h12, 32'h0, lat, d, e);
        n_checks++;
        if (d !== exp_d) begin
            n_fail++; $display("FAIL misalign_data: got %h expected %h", d, exp_d);
        end
        n_checks++;
        if (e !== exp_e) begin
            n_fail++; $display("FAIL misalign_err: got %b expected %b", e, exp_e);
        end
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++; $display("FAIL misalign_err_after: got %b expected 0", err);
        end
    endtask

    initial begin
        reset   = 1'b1;
        enable  = 1'b0;
        rw      = 1'b0;
        size    = 1'b0;
        address = 8'h0;
        data_in = 32'h0;
        test_reset();
        test_word();
        test_byte();
        test_back_to_back();
        test_reset_mid();
        test_misalign();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
